cpu_step_ctrl: RTL and testbench
================================

Name: cpu_step_ctrl

Overview:
Sequences the 16-bit CPU core by generating its clock-enable and reset from the board clock and user switches. Supports a power-on reset hold, single-step mode (one CPU cycle per debounced SW2 press), free-run mode with a divided enable rate, and a halt state requested by the CPU decoder. It sits between the board switches and the CPU core and replaces direct use of SW2 as a CPU clock.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive synchronized cycles an input must differ from its stable value before the stable value flips (>=1)
RUN_DIV, 4, cpu_ce period in RUN state, in board_clk cycles (>=1; 1 = continuous)
RST_CYCLES, 4, cycles cpu_rst is held after reset release (>=1)
CNT_W, 16, step_count width

Ports:
board_clk  in  1  single system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
sw_step  in  1  raw SW2 step button, asynchronous, bouncy
sw_mode  in  1  raw mode switch: 1 = run, 0 = single-step
halt_req  in  1  CPU decode flag, qualified only when cpu_ce=1
cpu_ce  out  1  CPU clock-enable, one board_clk cycle per CPU cycle
cpu_rst  out  1  synchronous reset to CPU core, active-high
halted  out  1  1 while in HALTED
state_o  out  3  current FSM state encoding
step_count  out  CNT_W  number of cpu_ce pulses issued since reset

Behaviour:
- Reset values: cpu_ce=0, cpu_rst=1, halted=0, state=RST_HOLD, step_count=0, sync flops=0, debounced values=0, debounce counters=0, run divider=0.
- Input conditioning, applied to sw_step and sw_mode independently:
  - 2-flop synchronizer.
  - Debounce: a counter increments while the synchronized input differs from the stable value and clears when it matches.
  - The stable value flips on the cycle the counter reaches DEBOUNCE_CYCLES; the counter then clears.
  - Pulses shorter than DEBOUNCE_CYCLES are never seen.
- step_edge = stable_step & ~stable_step_q: a one-cycle pulse per press.
- States: RST_HOLD=0, STEP_WAIT=1, STEP_FIRE=2, RUN=3, HALTED=4.
- RST_HOLD:
  - cpu_rst=1, cpu_ce=0.
  - Stays for RST_CYCLES cycles after reset deasserts.
  - Then goes to RUN if stable_mode=1, otherwise STEP_WAIT.
- STEP_WAIT:
  - cpu_ce=0.
  - step_edge -> STEP_FIRE.
  - stable_mode=1 -> RUN.
  - If both occur in the same cycle, the mode change wins and the step is discarded.
- STEP_FIRE:
  - cpu_ce=1 for exactly one cycle.
  - Next state is RUN if stable_mode=1, otherwise STEP_WAIT.
  - Latency: cpu_ce is high DEBOUNCE_CYCLES+3 edges after the first edge that samples sw_step=1 (input held clean).
- RUN:
  - The divider counts 0..RUN_DIV-1 and wraps; it is cleared on entry.
  - cpu_ce=1 when divider==RUN_DIV-1.
  - The first pulse arrives RUN_DIV cycles after entry.
  - step_edge is ignored.
  - stable_mode=0 -> STEP_WAIT immediately; a divider cycle in progress is dropped with no partial pulse.
- Halt:
  - halt_req=1 in any cycle with cpu_ce=1 -> HALTED next cycle. This has priority over a mode change.
  - halt_req while cpu_ce=0 is ignored.
- HALTED:
  - cpu_ce=0, halted=1.
  - Switch inputs are ignored; only reset exits.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Any in-progress cpu_ce pulse is cut.
- cpu_ce and cpu_rst are registered, never both 1.

Optional Feature:
STEP_COUNT_EN:
- Defined: step_count increments on every cycle with cpu_ce=1 and saturates at all-ones with no wrap.
- Undefined: step_count is tied to 0 and its counter logic is not built.

Decomposition:
- Package cpu_ctrl_pkg: the state encoding constants and state width (3).
- One sub-module, sw_debounce (synchronizer + debounce, parameter DEBOUNCE_CYCLES), instantiated twice: once for sw_step, once for sw_mode.

Test Plan:
1. Reset, sw_mode=0, release reset -> cpu_rst=1 for exactly 4 cycles, then state_o=1, cpu_ce=0.
2. STEP_WAIT, clean sw_step high for 40 cycles -> exactly one cpu_ce pulse at edge 19 after the first sampled high; step_count=1 (with STEP_COUNT_EN).
3. sw_step bouncing (3-cycle pulses ×5), then stable high -> exactly one cpu_ce pulse total; 10-cycle glitch alone -> zero pulses.
4. sw_mode=1 -> RUN; over 40 cycles -> exactly 10 cpu_ce pulses spaced 4 apart; drop sw_mode -> STEP_WAIT, no further pulses.
5. RUN with halt_req=1 at the third pulse -> state_o=4, halted=1, cpu_ce stays 0 for 100 cycles despite step presses; reset returns state_o=0.
6. Assert reset during a STEP_FIRE cycle -> cpu_ce falls without a clock edge, step_count=0; force step_count near 0xFFFF -> it saturates at 0xFFFF.

Source files
------------

// File: rtl/cpu_step_ctrl_pkg.sv
// Shared state encoding for the CPU step/run sequencer.
package cpu_ctrl_pkg;

   localparam int unsigned StateW = 3;

   typedef enum logic [StateW-1:0] {
      StRstHold  = 3'd0,
      StStepWait = 3'd1,
      StStepFire = 3'd2,
      StRun      = 3'd3,
      StHalted   = 3'd4
   } state_e;

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Switch/CPU-side signal bundle for cpu_step_ctrl; slave side is the sequencer.
interface cpu_step_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   import cpu_ctrl_pkg::*;

   logic              sw_step;
   logic              sw_mode;
   logic              halt_req;
   logic              cpu_ce;
   logic              cpu_rst;
   logic              halted;
   logic [StateW-1:0] state_o;
   logic [CNT_W-1:0]  step_count;

   modport master (
      output sw_step, sw_mode, halt_req,
      input  cpu_ce, cpu_rst, halted, state_o, step_count
   );

   modport slave (
      input  sw_step, sw_mode, halt_req,
      output cpu_ce, cpu_rst, halted, state_o, step_count
   );

endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a counting debouncer; the stable value
// flips only after DEBOUNCE_CYCLES consecutive differing samples.
module sw_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic stable
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

   logic            sync1_q, sync2_q;
   logic            stable_q, stable_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
         // Counter would reach DEBOUNCE_CYCLES on this edge: flip and clear.
         if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= din;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable/reset sequencer: reset hold, single-step, divided free-run
// and halt. Optional saturating step counter built when STEP_COUNT_EN is defined.
module cpu_step_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned RUN_DIV         = 4,
   parameter int unsigned RST_CYCLES      = 4,
   parameter int unsigned CNT_W           = 16
) (
   input logic            board_clk,
   input logic            reset,
   cpu_step_ctrl_if.slave bus
);

   localparam int unsigned DivW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
   localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   logic            step_stable, step_stable_q, mode_stable, step_edge;
   state_e          state_q, state_d;
   logic [DivW-1:0] div_q, div_d;
   logic [RstW-1:0] rst_cnt_q, rst_cnt_d;
   logic            cpu_ce_q, cpu_ce_d;
   logic            cpu_rst_q, cpu_rst_d;
   logic            halted_q, halted_d;

   sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_step_db (
      .clk    (board_clk),
      .rst    (reset),
      .din    (bus.sw_step),
      .stable (step_stable)
   );

   sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_mode_db (
      .clk    (board_clk),
      .rst    (reset),
      .din    (bus.sw_mode),
      .stable (mode_stable)
   );

   assign step_edge = step_stable & ~step_stable_q;

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      div_d     = '0;
      // halt_req is only meaningful while the CPU is actually executing a cycle
      if (cpu_ce_q && bus.halt_req) begin
         state_d = StHalted;
      end else begin
         case (state_q)
            StRstHold: begin
               if (rst_cnt_q == RstW'(RST_CYCLES - 1)) begin
                  state_d = mode_stable ? StRun : StStepWait;
               end else begin
                  rst_cnt_d = rst_cnt_q + 1'b1;
               end
            end
            StStepWait: begin
               if (mode_stable) begin
                  state_d = StRun;
               end else if (step_edge) begin
                  state_d = StStepFire;
               end
            end
            StStepFire: begin
               state_d = mode_stable ? StRun : StStepWait;
            end
            StRun: begin
               if (!mode_stable) begin
                  state_d = StStepWait;
               end else begin
                  div_d = (div_q == DivW'(RUN_DIV - 1)) ? '0 : div_q + 1'b1;
               end
            end
            StHalted: begin
               state_d = StHalted;
            end
            default: begin
               state_d = StRstHold;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so they align with state_o.
   always_comb begin
      cpu_ce_d  = (state_d == StStepFire) ||
                  ((state_q == StRun) && (state_d == StRun) &&
                   (div_q == DivW'(RUN_DIV - 1)));
      cpu_rst_d = (state_d == StRstHold);
      halted_d  = (state_d == StHalted);
   end

   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         state_q       <= StRstHold;
         rst_cnt_q     <= '0;
         div_q         <= '0;
         step_stable_q <= 1'b0;
         cpu_ce_q      <= 1'b0;
         cpu_rst_q     <= 1'b1;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         rst_cnt_q     <= rst_cnt_d;
         div_q         <= div_d;
         step_stable_q <= step_stable;
         cpu_ce_q      <= cpu_ce_d;
         cpu_rst_q     <= cpu_rst_d;
         halted_q      <= halted_d;
      end
   end

   assign bus.cpu_ce  = cpu_ce_q;
   assign bus.cpu_rst = cpu_rst_q;
   assign bus.halted  = halted_q;
   assign bus.state_o = state_q;

`ifdef STEP_COUNT_EN
   logic [CNT_W-1:0] step_cnt_q;

   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         step_cnt_q <= '0;
      end else if (cpu_ce_q && (step_cnt_q != {CNT_W{1'b1}})) begin
         step_cnt_q <= step_cnt_q + 1'b1;
      end
   end

   assign bus.step_count = step_cnt_q;
`else
   assign bus.step_count = '0;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed self-checking bench for cpu_step_ctrl (default parameters).
module tb_cpu_step_ctrl;

`ifdef STEP_COUNT_EN
   localparam int unsigned CntEn = 1;
`else
   localparam int unsigned CntEn = 0;
`endif

   logic board_clk = 1'b0;
   logic reset;
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 board_clk = ~board_clk;

   cpu_step_ctrl_if #(.CNT_W(16)) bus ();

   cpu_step_ctrl dut (
      .board_clk (board_clk),
      .reset     (reset),
      .bus       (bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge board_clk);
      #1;
   endtask

   task automatic run_cycles(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (bus.cpu_ce) pulses++;
      end
   endtask

   task automatic wait_state(input logic [2:0] st, input int budget, output int ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (bus.state_o == st) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic press_step();
      int p;
      bus.sw_step = 1'b1;
      run_cycles(30, p);
      bus.sw_step = 1'b0;
      run_cycles(30, p);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rst_hi, pulses, p, first, ok, last, gap_bad, np;

      // 1: reset values and reset hold length
      reset        = 1'b1;
      bus.sw_step  = 1'b0;
      bus.sw_mode  = 1'b0;
      bus.halt_req = 1'b0;
      repeat (3) tick();
      check_eq("rst_cpu_ce", bus.cpu_ce, 0);
      check_eq("rst_cpu_rst", bus.cpu_rst, 1);
      check_eq("rst_state", bus.state_o, 0);
      check_eq("rst_halted", bus.halted, 0);
      check_eq("rst_count", bus.step_count, 0);
      reset  = 1'b0;
      rst_hi = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.cpu_rst) rst_hi++;
         tick();
      end
      check_eq("rst_hold_len", rst_hi, 4);
      check_eq("after_hold_state", bus.state_o, 1);
      check_eq("after_hold_ce", bus.cpu_ce, 0);

      // 2: clean press, pulse at edge 19
      bus.sw_step = 1'b1;
      pulses = 0;
      first  = 0;
      for (int e = 1; e <= 40; e++) begin
         tick();
         if (bus.cpu_ce) begin
            pulses++;
            if (first == 0) first = e;
         end
      end
      check_eq("step_latency", first, 19);
      check_eq("step_pulses", pulses, 1);
      check_eq("step_count_1", bus.step_count, CntEn * 1);
      bus.sw_step = 1'b0;
      run_cycles(30, p);
      check_eq("release_no_pulse", p, 0);

      // 3: bounce then stable, and a lone short glitch
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         bus.sw_step = 1'b1;
         run_cycles(3, p);
         pulses += p;
         bus.sw_step = 1'b0;
         run_cycles(3, p);
         pulses += p;
      end
      bus.sw_step = 1'b1;
      run_cycles(40, p);
      pulses += p;
      bus.sw_step = 1'b0;
      run_cycles(30, p);
      pulses += p;
      check_eq("bounce_pulses", pulses, 1);
      bus.sw_step = 1'b1;
      run_cycles(10, p);
      pulses = p;
      bus.sw_step = 1'b0;
      run_cycles(40, p);
      pulses += p;
      check_eq("glitch_pulses", pulses, 0);
      check_eq("glitch_state", bus.state_o, 1);

      // 4: run mode, 10 pulses spaced 4 in 40 cycles
      bus.sw_mode = 1'b1;
      wait_state(3'd3, 40, ok);
      check_eq("enter_run", ok, 1);
      pulses  = 0;
      first   = 0;
      last    = 0;
      gap_bad = 0;
      for (int e = 1; e <= 40; e++) begin
         tick();
         if (bus.cpu_ce) begin
            if (pulses == 0) first = e;
            else if (e - last != 4) gap_bad++;
            last = e;
            pulses++;
         end
      end
      check_eq("run_pulses", pulses, 10);
      check_eq("run_first", first, 4);
      check_eq("run_gaps", gap_bad, 0);
      bus.sw_mode = 1'b0;
      wait_state(3'd1, 40, ok);
      check_eq("leave_run", ok, 1);
      run_cycles(30, p);
      check_eq("wait_no_pulse", p, 0);

      // 5: halt on third run pulse
      bus.sw_mode = 1'b1;
      wait_state(3'd3, 40, ok);
      check_eq("reenter_run", ok, 1);
      np = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.cpu_ce) np++;
         if (np == 3) begin
            bus.halt_req = 1'b1;
            break;
         end
      end
      check_eq("third_pulse_seen", np, 3);
      tick();
      bus.halt_req = 1'b0;
      check_eq("halt_state", bus.state_o, 4);
      check_eq("halt_flag", bus.halted, 1);
      check_eq("halt_ce", bus.cpu_ce, 0);
      pulses = 0;
      ok     = 0;
      for (int i = 0; i < 100; i++) begin
         bus.sw_step = ((i / 25) % 2 == 1);
         bus.sw_mode = ((i / 40) % 2 == 1);
         tick();
         if (bus.cpu_ce) pulses++;
         if (bus.state_o != 3'd4) ok++;
      end
      check_eq("halt_no_pulse", pulses, 0);
      check_eq("halt_sticky", ok, 0);
      reset = 1'b1;
      #1;
      check_eq("halt_reset_state", bus.state_o, 0);
      check_eq("halt_reset_flag", bus.halted, 0);

      // 6: saturation (when built) and async reset during STEP_FIRE
      bus.sw_step = 1'b0;
      bus.sw_mode = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      run_cycles(30, p);
      check_eq("reinit_state", bus.state_o, 1);
`ifdef STEP_COUNT_EN
      force dut.step_cnt_q = 16'hFFFD;
      #1;
      release dut.step_cnt_q;
      check_eq("preload_count", bus.step_count, 32'hFFFD);
      press_step();
      press_step();
      check_eq("count_ffff", bus.step_count, 32'hFFFF);
      press_step();
      check_eq("count_saturate", bus.step_count, 32'hFFFF);
`else
      press_step();
      check_eq("count_tied0", bus.step_count, 0);
`endif
      bus.sw_step = 1'b1;
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.cpu_ce) begin
            ok = 1;
            break;
         end
      end
      check_eq("fire_seen", ok, 1);
      check_eq("fire_state", bus.state_o, 2);
      reset = 1'b1;
      #1;
      check_eq("async_ce_cut", bus.cpu_ce, 0);
      check_eq("async_cpu_rst", bus.cpu_rst, 1);
      check_eq("async_state", bus.state_o, 0);
      check_eq("async_count", bus.step_count, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
